tx_huge_page_scheduler: RTL

- Sequences TX DMA reads out of the two host huge pages that the driver unlocks through the BAR2 register path.
- Serves pages in strict ping-pong order (1, 2, 1, …).
- Splits each page into read requests that never exceed `MAX_RD_QW` qwords and never cross a 4 KB boundary.
- Hands each request to the TX read engine, pulses the matching `huge_page_free_x` once the page is fully consumed, then requests a completion write to the host.

---
 rtl/tx_sched_pkg.sv | 19 +
 rtl/tx_rd_chunk_calc.sv | 28 ++
 rtl/tx_huge_page_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/tx_sched_pkg.sv
// Shared types and constants for the TX huge-page scheduler.
// One-hot FSM encoding plus datapath widths.
package tx_sched_pkg;

  localparam int QW_PER_4K = 512;
  localparam int RD_LEN_W  = 10;
  localparam int PAGE_QW_W = 32;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_LATCH = 7'b0000010,
    S_REQ   = 7'b0000100,
    S_WAIT  = 7'b0001000,
    S_HOLD  = 7'b0010000,
    S_FREE  = 7'b0100000,
    S_CPL   = 7'b1000000
  } state_t;

endpackage

// File: rtl/tx_rd_chunk_calc.sv
// Read chunk length: min of remaining qwords, max read size
// and the qwords left before the next 4 KB boundary.
module tx_rd_chunk_calc
  import tx_sched_pkg::*;
#(
  parameter int MAX_RD_QW = 64
) (
  input  logic [8:0]           i_addr_qw,
  input  logic [PAGE_QW_W-1:0] i_rem,
  output logic [RD_LEN_W-1:0]  o_chunk
);

  localparam logic [RD_LEN_W-1:0] MAXQ =
    RD_LEN_W'(MAX_RD_QW);

  logic [RD_LEN_W-1:0] w_room;
  logic [RD_LEN_W-1:0] w_lim;

  always_comb begin
    w_room  = RD_LEN_W'(QW_PER_4K)
            - {1'b0, i_addr_qw};
    w_lim   = (w_room < MAXQ) ? w_room : MAXQ;
    o_chunk = w_lim;
    if (i_rem < {22'd0, w_lim})
      o_chunk = i_rem[RD_LEN_W-1:0];
  end

endmodule

// File: rtl/tx_huge_page_scheduler.sv
// Ping-pong TX DMA read sequencer over two host huge pages:
// chunked reads, free pulse, then completion-write request.
module tx_huge_page_scheduler
  import tx_sched_pkg::*;
#(
  parameter int MAX_RD_QW = 64
) (
  input  logic                 trn_clk,
  input  logic                 reset_n,
  input  logic                 tx_enable,
  input  logic [63:0]          huge_page_addr_1,
  input  logic [63:0]          huge_page_addr_2,
  input  logic [PAGE_QW_W-1:0] huge_page_qwords_1,
  input  logic [PAGE_QW_W-1:0] huge_page_qwords_2,
  input  logic                 huge_page_status_1,
  input  logic                 huge_page_status_2,
  output logic                 huge_page_free_1,
  output logic                 huge_page_free_2,
  output logic                 rd_req,
  output logic [63:0]          rd_addr,
  output logic [RD_LEN_W-1:0]  rd_qwords,
  input  logic                 rd_ack,
  input  logic                 rd_done,
  output logic                 cpl_req,
  output logic                 cpl_page,
  output logic [PAGE_QW_W-1:0] cpl_qwords,
  input  logic                 cpl_ack,
  output logic                 cur_page,
  output logic                 busy
);

  state_t                r_state;
  state_t                w_next;
  logic [63:0]           r_addr;
  logic [PAGE_QW_W-1:0]  r_rem;
  logic [PAGE_QW_W-1:0]  r_len;
  logic                  r_page;
  logic [63:0]           r_rd_addr;
  logic [RD_LEN_W-1:0]   r_rd_qw;
  logic [RD_LEN_W-1:0]   w_chunk;
  logic                  w_status;
  logic                  w_to_req;
  logic [63:0]           w_sel_addr;
  logic [PAGE_QW_W-1:0]  w_sel_qw;

  tx_rd_chunk_calc #(
    .MAX_RD_QW (MAX_RD_QW)
  ) u_chunk (
    .i_addr_qw (r_addr[11:3]),
    .i_rem     (r_rem),
    .o_chunk   (w_chunk)
  );

  assign w_status   = r_page ? huge_page_status_2
                             : huge_page_status_1;
  assign w_sel_addr = r_page ? huge_page_addr_2
                             : huge_page_addr_1;
  assign w_sel_qw   = r_page ? huge_page_qwords_2
                             : huge_page_qwords_1;

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == S_IDLE):
        if (tx_enable && w_status) w_next = S_LATCH;
      (r_state == S_LATCH):
        w_next = (r_rem == '0) ? S_FREE : S_REQ;
      (r_state == S_REQ):
        if (rd_ack) w_next = S_WAIT;
      (r_state == S_WAIT):
        if (rd_done) begin
          if (r_rem == '0)    w_next = S_FREE;
          else if (tx_enable) w_next = S_REQ;
          else                w_next = S_HOLD;
        end
      (r_state == S_HOLD):
        if (tx_enable) w_next = S_REQ;
      (r_state == S_FREE):
        w_next = S_CPL;
      (r_state == S_CPL):
        if (cpl_ack) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  assign w_to_req = (w_next == S_REQ)
                 && (r_state != S_REQ);

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_len     <= '0;
      r_page    <= 1'b0;
      r_rd_addr <= '0;
      r_rd_qw   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_LATCH) begin
        r_addr <= {w_sel_addr[63:3], 3'b000};
        r_rem  <= w_sel_qw;
        r_len  <= w_sel_qw;
      end
      if (r_state == S_REQ && rd_ack) begin
        r_addr <= r_addr + {51'd0, w_chunk, 3'b000};
        r_rem  <= r_rem - {22'd0, w_chunk};
      end
      // Request fields freeze on entry so they stay stable until ack.
      if (w_to_req) begin
        r_rd_addr <= r_addr;
        r_rd_qw   <= w_chunk;
      end
      if (r_state == S_CPL && cpl_ack)
        r_page <= ~r_page;
    end
  end

  assign rd_req           = (r_state == S_REQ);
  assign rd_addr          = r_rd_addr;
  assign rd_qwords        = r_rd_qw;
  assign huge_page_free_1 = (r_state == S_FREE) && !r_page;
  assign huge_page_free_2 = (r_state == S_FREE) &&  r_page;
  assign cpl_req          = (r_state == S_CPL);
  assign cpl_page         = r_page;
  assign cpl_qwords       = r_len;
  assign cur_page         = r_page;
  assign busy             = (r_state != S_IDLE);

endmodule
